// File: rtl/xnor_serial_cmp_arbiter_if.sv
// Requester/result bundle for the XNOR compare sequencer.
// master = requester side, slave = arbiter side.
interface xnor_serial_cmp_arbiter_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             eq;
  logic [CW-1:0]    mism_cnt;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, busy, done, eq, mism_cnt
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, busy, done, eq, mism_cnt
  );
endinterface

// File: rtl/xnor_serial_cmp_arbiter.sv
// Round-robin arbiter that streams a granted operand pair LSB-first through an
// external single-bit XNOR cell and reports the mismatch count and equality.
module xnor_serial_cmp_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  xnor_serial_cmp_arbiter_if.slave  bus,
  output logic                      xa,
  output logic                      xb,
  input  logic                      xs
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t           state;
  logic             lp;
  logic             win;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    acc;
  logic [CW-1:0]    acc_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;

  // Contention goes to whoever was not served last; a lone request always wins.
  always_comb begin
    win = 1'b0;
    if (bus.req0 && bus.req1) win = ~lp;
    else                      win = bus.req1;
    acc_nxt = acc + (xs ? CW'(0) : CW'(1));
  end

  always_comb begin
    xa = 1'b0;
    xb = 1'b0;
    if (state == COMPARE) begin
      xa = sa[0];
      xb = sb[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lp           <= 1'b1;
      cnt          <= '0;
      acc          <= '0;
      sa           <= '0;
      sb           <= '0;
      bus.gnt0     <= 1'b0;
      bus.gnt1     <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.eq       <= 1'b0;
      bus.mism_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            sa       <= win ? bus.a1 : bus.a0;
            sb       <= win ? bus.b1 : bus.b0;
            acc      <= '0;
            cnt      <= '0;
            bus.gnt0 <= ~win;
            bus.gnt1 <= win;
            bus.busy <= 1'b1;
            state    <= COMPARE;
          end
        end
        COMPARE: begin
          acc <= acc_nxt;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            bus.mism_cnt <= acc_nxt;
            bus.eq       <= (acc_nxt == '0);
            bus.done     <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          lp       <= bus.gnt1;
          bus.gnt0 <= 1'b0;
          bus.gnt1 <= 1'b0;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/xnor_serial_cmp_arbiter.md
Name: xnor_serial_cmp_arbiter

Overview:
Sequencer and arbiter for the shared single-bit NOR-built XNOR cell, which sits outside this block. Two requesters submit WIDTH-bit operand pairs. The block grants one requester at a time using round-robin, then streams the latched operand bits LSB-first through the cell, one bit per clock. It counts mismatching bits and reports equality with a done pulse. The XNOR cell stays a separate instance; this block only drives its inputs and samples its output.

Parameters:
WIDTH, 8, operand width in bits (>=2)
CW, $clog2(WIDTH+1), mismatch counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
req0  input  1  requester 0 request
a0  input  WIDTH  requester 0 operand A
b0  input  WIDTH  requester 0 operand B
req1  input  1  requester 1 request
a1  input  WIDTH  requester 1 operand A
b1  input  WIDTH  requester 1 operand B
gnt0  output  1  requester 0 owns the cell
gnt1  output  1  requester 1 owns the cell
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
eq  output  1  1 when the last compared operands were equal
mism_cnt  output  CW  number of differing bit positions in the last operation
xa  output  1  to XNOR cell input a
xb  output  1  to XNOR cell input b
xs  input  1  from XNOR cell output (1 = bits equal), combinational in the same cycle

Behaviour:
- States: IDLE, COMPARE, DONE. Internal regs: last-grant pointer `lp`, bit counter, shift regs `sa` and `sb`, mismatch accumulator.
- Reset (async, any state) forces:
  - state = IDLE, lp = 1, so requester 0 wins first.
  - all outputs 0: gnt0, gnt1, busy, done, eq, mism_cnt, xa, xb.
  - shift regs and counters cleared.
- IDLE, no req: stay in IDLE.
- IDLE, any req at edge E0:
  - Winner when only one req is high: that requester.
  - Winner when both are high: the requester not equal to lp.
  - Latch winner's a into sa and b into sb; clear accumulator and bit counter.
  - Set the winner's gnt and busy; go to COMPARE.
- COMPARE, edges E1..EWIDTH:
  - xa = sa[0], xb = sb[0] (combinational from regs).
  - At each edge, if xs == 0, accumulator += 1.
  - Shift sa and sb right by 1; bit counter += 1.
  - At EWIDTH (bit counter reaches WIDTH-1 before that edge): mism_cnt <= final accumulator, eq <= (final accumulator == 0), done <= 1, state -> DONE.
- DONE:
  - done = 1 for exactly one cycle; gnt and busy stay high.
  - At E(WIDTH+1): gnt, busy and done -> 0; lp <= winner; state -> IDLE.
- xa and xb are 0 in IDLE and DONE.
- eq and mism_cnt hold their values until the next operation's EWIDTH. They are not cleared at grant.
- Latency: done is high in the cycle after EWIDTH, i.e. WIDTH+1 edges after the granting edge.
- Minimum spacing: one IDLE cycle, so the next grant happens at E(WIDTH+2) at the earliest.
- Requester-side rules:
  - Operands are sampled only at the grant edge.
  - Changes to a/b or deassertion of req during COMPARE or DONE are ignored; the operation runs to completion.
  - A req still high at the next IDLE edge is treated as a new request.
- Accumulator saturation cannot occur: its maximum value is WIDTH, which CW holds.
- Reset asserted mid-operation:
  - Operation aborted; no done pulse.
  - eq and mism_cnt cleared; lp returns to 1.

Test Plan:
- WIDTH=8. Reset, then req0 with a0=b0=8'hA5 -> gnt0=1 at E0; done pulse after E8; eq=1, mism_cnt=0; busy low after E9.
- req0 with a0=8'hFF, b0=8'h00 -> eq=0, mism_cnt=8. Check xa=1, xb=0 on all 8 COMPARE cycles.
- After reset, req0 and req1 held high together with distinct operands -> grant order gnt0, gnt1, gnt0. Each grant is separated by exactly one IDLE cycle (grant edges 10 clocks apart).
- req1 with a1=8'h0F, b1=8'h0E; req1 dropped and a1 changed to 8'h00 right after E0 -> operation completes with mism_cnt=1, eq=0.
- a0=8'h01, b0=8'h80 -> xa sequence 1,0,0,0,0,0,0,0 and xb sequence 0,0,0,0,0,0,0,1 (LSB first); mism_cnt=2.
- rst pulsed mid-cycle during the 4th COMPARE bit -> all outputs 0 immediately, with no clock edge needed. With both reqs high afterwards, gnt0 is granted first.
